// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART TX FIFO write port between two word requesters.
// A granted word is latched, written least significant byte first, then acked for one cycle.
module uart_tx_arbiter #(
    parameter int NBYTES = 4,
    localparam int DATA_W = 8 * NBYTES,
    localparam int SIZE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    input  logic [SIZE_W-1:0] size0,
    output logic              ack0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    input  logic [SIZE_W-1:0] size1,
    output logic              ack1,
    input  logic              wr_full,
    output logic              wr,
    output logic [7:0]        w_data,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DATA_W-1:0]   shift_reg;
    logic [DATA_W-1:0]   shift_nxt;
    logic [SIZE_W-1:0]   remaining;
    logic [SIZE_W-1:0]   remaining_nxt;
    logic                owner_q;
    logic                owner_nxt;
    logic                grant_vld;
    logic                grant_idx;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant_vld = req0 | req1;
        grant_idx = (req0 && req1) ? ~owner_q : req1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            remaining <= '0;
            owner_q   <= 1'b1;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            remaining <= remaining_nxt;
            owner_q   <= owner_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        shift_nxt     = shift_reg;
        remaining_nxt = remaining;
        owner_nxt     = owner_q;
        wr            = 1'b0;
        ack0          = 1'b0;
        ack1          = 1'b0;
        busy          = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (grant_vld) begin
                    owner_nxt     = grant_idx;
                    shift_nxt     = grant_idx ? data1 : data0;
                    remaining_nxt = grant_idx ? size1 : size0;
                    state_nxt     = SEND;
                end
            end
            SEND: begin
                wr = ~wr_full;
                // A stalled FIFO freezes the byte on w_data until it is accepted.
                if (!wr_full) begin
                    shift_nxt = shift_reg >> 8;
                    if (remaining == '0) begin
                        state_nxt = DONE;
                    end else begin
                        remaining_nxt = remaining - SIZE_W'(1);
                    end
                end
            end
            DONE: begin
                ack0      = ~owner_q;
                ack1      = owner_q;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign w_data = shift_reg[7:0];
    assign owner  = owner_q;

    a_ack_exclusive : assert property (@(posedge clk) disable iff (reset) !(ack0 && ack1));
    a_wr_only_send  : assert property (@(posedge clk) disable iff (reset) wr |-> (state == SEND));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: byte-queue reference model checked every cycle,
// plus directed scenarios with hand-computed byte, cycle and ack expectations.
module tb_uart_tx_arbiter;

    typedef int iq_t[$];

    logic        clk;
    logic        reset;
    logic        req0, req1;
    logic [31:0] data0, data1;
    logic [1:0]  size0, size1;
    logic        ack0, ack1;
    logic        wr_full;
    logic        wr;
    logic [7:0]  w_data;
    logic        busy;
    logic        owner;

    uart_tx_arbiter #(.NBYTES(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .data0   (data0),
        .size0   (size0),
        .ack0    (ack0),
        .req1    (req1),
        .data1   (data1),
        .size1   (size1),
        .ack1    (ack1),
        .wr_full (wr_full),
        .wr      (wr),
        .w_data  (w_data),
        .busy    (busy),
        .owner   (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Pending words per requester; the front word is driven until acked.
    logic [31:0] qd0[$], qd1[$];
    logic [1:0]  qs0[$], qs1[$];
    bit corrupt = 1'b0;
    bit bp_en = 1'b0;
    int bp_t0 = 0;

    // Observed traffic
    int wr_log[$], wr_cyc[$], ack_ch[$], ack_cyc[$];

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a granted word becomes a queue of size+1 bytes,
    // one byte leaves per cycle the FIFO is not full, then one ack cycle.
    int          m_phase = 0;
    logic [7:0]  m_q[$];
    logic        m_owner = 1'b1;
    logic        m_g;
    logic [31:0] m_d;
    logic [1:0]  m_s;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0;
            m_q.delete();
            m_owner = 1'b1;
        end else begin
            case (m_phase)
                0: if (req0 || req1) begin
                    m_g = (req0 && req1) ? !m_owner : req1;
                    m_owner = m_g;
                    m_d = m_g ? data1 : data0;
                    m_s = m_g ? size1 : size0;
                    for (int i = 0; i <= int'(m_s); i++) m_q.push_back(m_d[8*i +: 8]);
                    m_phase = 1;
                end
                1: if (!wr_full) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
    end

    logic exp_wr;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_wr = (m_phase == 1) && !wr_full;
            check("wr", int'(wr), int'(exp_wr));
            if (exp_wr && m_q.size() > 0) check("w_data", int'(w_data), int'(m_q[0]));
            check("ack0", int'(ack0), int'(m_phase == 2 && !m_owner));
            check("ack1", int'(ack1), int'(m_phase == 2 && m_owner));
            check("busy", int'(busy), int'(m_phase != 0));
            check("owner", int'(owner), int'(m_owner));
            if (wr) begin
                wr_log.push_back(int'(w_data));
                wr_cyc.push_back(cyc);
            end
            if (ack0) begin
                ack_ch.push_back(0);
                ack_cyc.push_back(cyc);
            end
            if (ack1) begin
                ack_ch.push_back(1);
                ack_cyc.push_back(cyc);
            end
        end
    end

    // One clock of the requester side: drop a word once its ack was seen.
    task automatic cycle();
        logic a0, a1;
        @(negedge clk);
        a0 = ack0;
        a1 = ack1;
        @(posedge clk);
        #1;
        cyc++;
        if (a0 && qd0.size() != 0) begin
            void'(qd0.pop_front());
            void'(qs0.pop_front());
        end
        if (a1 && qd1.size() != 0) begin
            void'(qd1.pop_front());
            void'(qs1.pop_front());
        end
        req0 = (qd0.size() != 0);
        if (req0) begin
            data0 = corrupt ? 32'hFFFF_FFFF : qd0[0];
            size0 = corrupt ? 2'd0 : qs0[0];
        end
        req1 = (qd1.size() != 0);
        if (req1) begin
            data1 = qd1[0];
            size1 = qs1[0];
        end
        wr_full = bp_en && (cyc - bp_t0 >= 2) && (cyc - bp_t0 <= 4);
    endtask

    task automatic run(string tag, int max_cyc);
        int n;
        n = 0;
        while (qd0.size() != 0 || qd1.size() != 0 || busy) begin
            if (n >= max_cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s timeout: still busy after %0d cycles, expected idle", tag, n);
                return;
            end
            cycle();
            n++;
        end
    endtask

    task automatic clear_logs();
        wr_log.delete();
        wr_cyc.delete();
        ack_ch.delete();
        ack_cyc.delete();
    endtask

    function automatic iq_t rel(iq_t q, int t0);
        iq_t r;
        foreach (q[i]) r.push_back(q[i] - t0);
        return r;
    endfunction

    task automatic check_q(string tag, iq_t act, iq_t exp);
        check({tag, " count"}, act.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            check($sformatf("%s[%0d]", tag, i), (i < act.size()) ? act[i] : -1, exp[i]);
    endtask

    task automatic push0(logic [31:0] d, logic [1:0] s);
        qd0.push_back(d);
        qs0.push_back(s);
    endtask

    task automatic push1(logic [31:0] d, logic [1:0] s);
        qd1.push_back(d);
        qs1.push_back(s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    int t0;
    iq_t eb, ec, ea, eac;

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        data0 = '0; data1 = '0;
        size0 = '0; size1 = '0;
        wr_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state (reset still asserted)
        check("rst wr", int'(wr), 0);
        check("rst w_data", int'(w_data), 0);
        check("rst ack0", int'(ack0), 0);
        check("rst ack1", int'(ack1), 0);
        check("rst busy", int'(busy), 0);
        check("rst owner", int'(owner), 1);
        chk_en = 1'b1;
        reset = 1'b0;

        // Single 4-byte word from requester 0
        clear_logs();
        t0 = cyc + 1;
        push0(32'hA1B2C3D4, 2'd3);
        run("single", 50);
        eb = '{32'hD4, 32'hC3, 32'hB2, 32'hA1}; check_q("single bytes", wr_log, eb);
        ec = '{1, 2, 3, 4};                     check_q("single wr cyc", rel(wr_cyc, t0), ec);
        ea = '{0};                              check_q("single ack ch", ack_ch, ea);
        eac = '{5};                             check_q("single ack cyc", rel(ack_cyc, t0), eac);
        check("single owner", int'(owner), 0);

        // Tie straight after reset: requester 0 first
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        clear_logs();
        t0 = cyc + 1;
        push0(32'hA1B2C3D4, 2'd3);
        push1(32'h00000055, 2'd0);
        run("tie", 50);
        eb = '{32'hD4, 32'hC3, 32'hB2, 32'hA1, 32'h55}; check_q("tie bytes", wr_log, eb);
        ec = '{1, 2, 3, 4, 7};                          check_q("tie wr cyc", rel(wr_cyc, t0), ec);
        ea = '{0, 1};                                   check_q("tie ack ch", ack_ch, ea);
        eac = '{5, 8};                                  check_q("tie ack cyc", rel(ack_cyc, t0), eac);

        // Backpressure: FIFO full during cycles 2..4
        clear_logs();
        t0 = cyc + 1;
        bp_t0 = t0;
        bp_en = 1'b1;
        push1(32'h00001234, 2'd1);
        run("bp", 50);
        bp_en = 1'b0;
        wr_full = 1'b0;
        eb = '{32'h34, 32'h12}; check_q("bp bytes", wr_log, eb);
        ec = '{1, 5};           check_q("bp wr cyc", rel(wr_cyc, t0), ec);
        ea = '{1};              check_q("bp ack ch", ack_ch, ea);
        eac = '{6};             check_q("bp ack cyc", rel(ack_cyc, t0), eac);

        // Fairness: both requesters always have work queued
        clear_logs();
        push0(32'h01020304, 2'd3); push0(32'h00000A0B, 2'd1);
        push0(32'h000000EE, 2'd0); push0(32'h00C0FFEE, 2'd2);
        push1(32'h00000099, 2'd0); push1(32'h11223344, 2'd3);
        push1(32'h0000BEEF, 2'd1); push1(32'h00123456, 2'd2);
        run("fair", 200);
        ea = '{0, 1, 0, 1, 0, 1, 0, 1}; check_q("fair ack ch", ack_ch, ea);
        check("fair byte total", wr_log.size(), 20);

        // Reset in the middle of a 4-byte frame, after the 2nd byte
        clear_logs();
        t0 = cyc + 1;
        push0(32'hCAFEF00D, 2'd3);
        cycle();
        cycle();
        cycle();
        reset = 1'b1;
        qd0.delete();
        qs0.delete();
        cycle();
        check("mid rst wr", int'(wr), 0);
        check("mid rst w_data", int'(w_data), 0);
        check("mid rst busy", int'(busy), 0);
        check("mid rst ack0", int'(ack0), 0);
        check("mid rst owner", int'(owner), 1);
        reset = 1'b0;
        repeat (3) cycle();
        eb = '{32'h0D, 32'hF0}; check_q("mid rst bytes", wr_log, eb);
        ec = '{1, 2};           check_q("mid rst wr cyc", rel(wr_cyc, t0), ec);
        check("mid rst acks", ack_ch.size(), 0);
        clear_logs();
        push1(32'h00000077, 2'd0);
        run("after rst", 50);
        eb = '{32'h77}; check_q("after rst bytes", wr_log, eb);
        ea = '{1};      check_q("after rst ack ch", ack_ch, ea);

        // Inputs changed after grant are ignored
        clear_logs();
        push0(32'h11223344, 2'd3);
        cycle();
        corrupt = 1'b1;
        run("latch", 50);
        corrupt = 1'b0;
        eb = '{32'h44, 32'h33, 32'h22, 32'h11}; check_q("latch bytes", wr_log, eb);
        ea = '{0};                              check_q("latch ack ch", ack_ch, ea);

        repeat (2) cycle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
